// File: rtl/reg_file_param_pkg.sv
// Shared helpers for the parametrised register file: width helpers and the
// byte-merge used by both the entry write path and the read bypass path.
package reg_file_param_pkg;

  localparam int MAX_DATA_W = 256;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_DEPTH  = 1 << DEFAULT_ADDR_W;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // Callers zero-extend into the wide form and size-cast the result back down.
  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0] old_v,
    input logic [MAX_DATA_W-1:0] new_v,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_v;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Write/read bus of the register file. All signals are level-based, no
// handshake: a write is taken on every rising edge with wr_en=1, reads are
// combinational and always valid.
interface reg_file_param_if
  import reg_file_param_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic                     clr;
  logic                     wr_en;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        w_data;
  logic [be_w(DATA_W)-1:0]  w_be;
  logic [ADDR_W-1:0]        r_addr0;
  logic [DATA_W-1:0]        r_data0;
  logic                     r_vld0;
  logic [ADDR_W-1:0]        r_addr1;
  logic [DATA_W-1:0]        r_data1;
  logic                     r_vld1;
  logic                     any_vld;

  modport master (
    output clr, wr_en, w_addr, w_data, w_be, r_addr0, r_addr1,
    input  r_data0, r_vld0, r_data1, r_vld1, any_vld
  );

  modport slave (
    input  clr, wr_en, w_addr, w_data, w_be, r_addr0, r_addr1,
    output r_data0, r_vld0, r_data1, r_vld1, any_vld
  );
endinterface

// File: rtl/reg_file_param_reg_entry.sv
// One register-file entry: DATA_W flops with async reset, sync clear,
// byte-enabled load and a valid flag.
module reg_entry
  import reg_file_param_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                BE_W      = DATA_W / 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              vld_q, vld_d;

  // An all-zero byte enable is a no-op: neither data nor valid moves.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr_i) begin
      data_d = RESET_VAL;
      vld_d  = 1'b0;
    end else if (we_i && (|be_i)) begin
      data_d = DATA_W'(merge_be(MAX_DATA_W'(data_q), MAX_DATA_W'(data_i),
                                MAX_BE_W'(be_i)));
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: 2^ADDR_W entries, one byte-enabled write port,
// two combinational read ports with optional same-cycle write forwarding.
module reg_file_param
  import reg_file_param_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 3,
  parameter int                BYPASS    = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_param_if.slave bus
);

  localparam int BE_W  = be_w(DATA_W);
  localparam int DEPTH = depth_of(ADDR_W);

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("reg_file_param: DATA_W must be a multiple of 8");
  end
  if (DATA_W > MAX_DATA_W) begin : g_too_wide
    $error("reg_file_param: DATA_W exceeds MAX_DATA_W");
  end

  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_vld;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    reg_entry #(
      .DATA_W    (DATA_W),
      .BE_W      (BE_W),
      .RESET_VAL (RESET_VAL)
    ) u_entry (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (bus.clr),
      .we_i   (bus.wr_en && (bus.w_addr == ADDR_W'(i))),
      .be_i   (bus.w_be),
      .data_i (bus.w_data),
      .data_o (ent_data[i]),
      .vld_o  (ent_vld[i])
    );
  end

  // Forwarding is suppressed during clr and while reset is held, so reads
  // then show the stored (cleared) state.
  logic byp_act;
  assign byp_act = (BYPASS != 0) && bus.wr_en && !bus.clr && !reset && (|bus.w_be);

  logic [DATA_W-1:0] fwd_data;
  assign fwd_data = DATA_W'(merge_be(MAX_DATA_W'(ent_data[bus.w_addr]),
                                     MAX_DATA_W'(bus.w_data),
                                     MAX_BE_W'(bus.w_be)));

  always_comb begin
    bus.r_data0 = ent_data[bus.r_addr0];
    bus.r_vld0  = ent_vld[bus.r_addr0];
    if (byp_act && (bus.r_addr0 == bus.w_addr)) begin
      bus.r_data0 = fwd_data;
      bus.r_vld0  = 1'b1;
    end
  end

  always_comb begin
    bus.r_data1 = ent_data[bus.r_addr1];
    bus.r_vld1  = ent_vld[bus.r_addr1];
    if (byp_act && (bus.r_addr1 == bus.w_addr)) begin
      bus.r_data1 = fwd_data;
      bus.r_vld1  = 1'b1;
    end
  end

  // Derived from the valid flops, so it reflects the state after the last edge.
  assign bus.any_vld = |ent_vld;

endmodule
